// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
// Shared types and constants for the two-port data-memory arbiter.
//   arb_state_t : ownership FSM encoding (IDLE, OWN0, OWN1)
//   port_id_t   : identifies a requester (0 = CPU data port, 1 = secondary master)
//   NUM_PORTS   : number of requesters sharing the memory
//   cnt_width() : width of the burst counter, which must be able to hold MAX_BURST itself
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef logic port_id_t;

  localparam int NUM_PORTS = 2;

  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
// One requester's connection to the data-memory arbiter.
//   req    : request, held by the requester until granted
//   we     : 1 = write, 0 = read
//   addr   : byte address (word aligned)
//   wdata  : write data
//   gnt    : grant, combinational in the request cycle
//   rdata  : registered read data
//   rvalid : one-cycle pulse when rdata carries a new read result
// Modports: master = requester side, slave = arbiter side.
interface dmem_arbiter_if #(
  parameter int n = 32
);
  logic         req;
  logic         we;
  logic [n-1:0] addr;
  logic [n-1:0] wdata;
  logic         gnt;
  logic [n-1:0] rdata;
  logic         rvalid;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rdata, rvalid
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rdata, rvalid
  );
endinterface

// File: rtl/dmem_arbiter_rr_burst_ctrl.sv
// rr_burst_ctrl
// Round-robin grant generator with a bounded burst. The current owner keeps
// the memory for up to MAX_BURST consecutive grants while the other port
// waits; a lone requester is always granted immediately.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   req0, req1 : port requests
//   gnt0, gnt1 : combinational, mutually exclusive grants
module rr_burst_ctrl
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  localparam int CW = cnt_width(MAX_BURST);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BURST);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  arb_state_t    state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  port_id_t      last_r, last_s;
  logic          gnt0_s, gnt1_s;

  // Grant decision: lone requester wins; on a tie the owner keeps the
  // memory until its burst is used up, then the port that did not go last wins.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    case ({req0, req1})
      2'b10: gnt0_s = 1'b1;
      2'b01: gnt1_s = 1'b1;
      2'b11: begin
        if (state_r == OWN0 && cnt_r < CNT_MAX) begin
          gnt0_s = 1'b1;
        end else if (state_r == OWN1 && cnt_r < CNT_MAX) begin
          gnt1_s = 1'b1;
        end else if (last_r == 1'b1) begin
          gnt0_s = 1'b1;
        end else begin
          gnt1_s = 1'b1;
        end
      end
      default: begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
      end
    endcase
  end

  // Next ownership state: continuing owner counts up (saturating), a new
  // owner restarts at 1, an idle cycle clears burst tracking.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    last_s  = last_r;
    if (gnt0_s) begin
      last_s = 1'b0;
      if (state_r == OWN0) begin
        cnt_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
      end else begin
        state_s = OWN0;
        cnt_s   = CNT_ONE;
      end
    end else if (gnt1_s) begin
      last_s = 1'b1;
      if (state_r == OWN1) begin
        cnt_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
      end else begin
        state_s = OWN1;
        cnt_s   = CNT_ONE;
      end
    end else begin
      state_s = IDLE;
      cnt_s   = CNT_ZERO;
    end
  end

  // Ownership state register; last resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      last_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      last_r  <= last_s;
    end
  end

  assign gnt0 = gnt0_s;
  assign gnt1 = gnt1_s;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one single-port data memory (async read, posedge write) between the
// CPU data port (p0) and a secondary master (p1).
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   p0, p1         : requester interfaces (dmem_arbiter_if.slave)
//   mem_we         : memory write enable
//   mem_addr       : memory address (granted port, p0 when idle)
//   mem_wdata      : memory write data (granted port, p0 when idle)
//   mem_rdata      : memory read data
// Optional (macro DMEM_ARB_STATS_EN):
//   gcnt0, gcnt1   : per-port grant counters (wrap at 2^32)
//   stall_cnt      : cycles a requesting port went ungranted (wrap at 2^32)
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int n         = 32,
  parameter int MAX_BURST = 4
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  p0,
  dmem_arbiter_if.slave  p1,
  output logic           mem_we,
  output logic [n-1:0]   mem_addr,
  output logic [n-1:0]   mem_wdata,
  input  logic [n-1:0]   mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]    gcnt0,
  output logic [31:0]    gcnt1,
  output logic [31:0]    stall_cnt
`endif
);

  logic                 gnt0_s, gnt1_s;
  logic                 read0_s, read1_s;
  logic                 mem_we_s;
  logic [n-1:0]         mem_addr_s, mem_wdata_s;
  logic [n-1:0]         rdata0_r, rdata1_r;
  logic [NUM_PORTS-1:0] rvalid_r;

  rr_burst_ctrl #(
    .MAX_BURST(MAX_BURST)
  ) u_ctrl (
    .clk  (clk),
    .reset(reset),
    .req0 (p0.req),
    .req1 (p1.req),
    .gnt0 (gnt0_s),
    .gnt1 (gnt1_s)
  );

  // Memory mux: the granted port drives the memory; port 0 passes through when idle.
  always_comb begin
    mem_addr_s  = p0.addr;
    mem_wdata_s = p0.wdata;
    mem_we_s    = (gnt0_s & p0.we) | (gnt1_s & p1.we);
    if (gnt1_s) begin
      mem_addr_s  = p1.addr;
      mem_wdata_s = p1.wdata;
    end else begin
      mem_addr_s  = p0.addr;
      mem_wdata_s = p0.wdata;
    end
  end

  assign read0_s = gnt0_s & ~p0.we;
  assign read1_s = gnt1_s & ~p1.we;

  // Read return: capture the async memory output at the end of a read grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata0_r <= {n{1'b0}};
      rdata1_r <= {n{1'b0}};
      rvalid_r <= {NUM_PORTS{1'b0}};
    end else begin
      rvalid_r <= {read1_s, read0_s};
      if (read0_s) begin
        rdata0_r <= mem_rdata;
      end
      if (read1_s) begin
        rdata1_r <= mem_rdata;
      end
    end
  end

  assign mem_we    = mem_we_s;
  assign mem_addr  = mem_addr_s;
  assign mem_wdata = mem_wdata_s;

  assign p0.gnt    = gnt0_s;
  assign p1.gnt    = gnt1_s;
  assign p0.rdata  = rdata0_r;
  assign p1.rdata  = rdata1_r;
  assign p0.rvalid = rvalid_r[0];
  assign p1.rvalid = rvalid_r[1];

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] gcnt0_r, gcnt1_r, stall_cnt_r;
  logic [31:0] stall_inc_s;

  assign stall_inc_s = 32'(p0.req & ~gnt0_s) + 32'(p1.req & ~gnt1_s);

  // Grant and stall statistics, free-running modulo 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      gcnt0_r     <= 32'd0;
      gcnt1_r     <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else begin
      gcnt0_r     <= gcnt0_r + 32'(gnt0_s);
      gcnt1_r     <= gcnt1_r + 32'(gnt1_s);
      stall_cnt_r <= stall_cnt_r + stall_inc_s;
    end
  end

  assign gcnt0     = gcnt0_r;
  assign gcnt1     = gcnt1_r;
  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Scoreboard bench: the drivers push expected grants / read returns into
// queues, and a negedge monitor pops and compares whenever the DUT presents
// a grant cycle or an rvalid. Instance "a" uses MAX_BURST=4, instance "b"
// uses MAX_BURST=1. Both share one behavioural memory (only "a" writes).
module tb_dmem_arbiter;

  typedef struct packed {
    logic        g0;
    logic        g1;
    logic        we;
    logic [31:0] addr;
  } gexp_t;

  logic clk = 1'b0;
  logic reset;
  logic mem_init;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  gexp_t       ga_q[$];
  gexp_t       gb_q[$];
  logic [47:0] rd_q[4][$];

  dmem_arbiter_if #(.n(32)) pa0 ();
  dmem_arbiter_if #(.n(32)) pa1 ();
  dmem_arbiter_if #(.n(32)) pb0 ();
  dmem_arbiter_if #(.n(32)) pb1 ();

  logic        mem_we_a, mem_we_b;
  logic [31:0] mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic [31:0] mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic [31:0] gcnt0_a, gcnt1_a, stall_a, gcnt0_b, gcnt1_b, stall_b;

  assign mem_rdata_a = mem[mem_addr_a[9:2]];
  assign mem_rdata_b = mem[mem_addr_b[9:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    end else if (mem_we_a) begin
      mem[mem_addr_a[9:2]] <= mem_wdata_a;
    end
  end

  dmem_arbiter #(.n(32), .MAX_BURST(4)) dut_a (
    .clk(clk), .reset(reset), .p0(pa0), .p1(pa1),
    .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata_a)
`ifdef DMEM_ARB_STATS_EN
    , .gcnt0(gcnt0_a), .gcnt1(gcnt1_a), .stall_cnt(stall_a)
`endif
  );

  dmem_arbiter #(.n(32), .MAX_BURST(1)) dut_b (
    .clk(clk), .reset(reset), .p0(pb0), .p1(pb1),
    .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b)
`ifdef DMEM_ARB_STATS_EN
    , .gcnt0(gcnt0_b), .gcnt1(gcnt1_b), .stall_cnt(stall_b)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Read-return check: value {cycle, data} must match the oldest expectation.
  task automatic chk_rv(input int idx, input logic rv, input logic [31:0] rd, input string nm);
    logic [47:0] e;
    if (rv) begin
      if (rd_q[idx].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s: got rvalid with rdata=%h, required no response", nm, rd);
      end else begin
        e = rd_q[idx].pop_front();
        chk(nm, {16'd0, 16'(cyc), rd}, {16'd0, e});
      end
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    gexp_t e;
    chk("onehot_a", {63'd0, pa0.gnt & pa1.gnt}, 64'd0);
    chk("onehot_b", {63'd0, pb0.gnt & pb1.gnt}, 64'd0);
    if (ga_q.size() > 0) begin
      e = ga_q.pop_front();
      chk("grant_a", {29'd0, pa0.gnt, pa1.gnt, mem_we_a, mem_addr_a}, {29'd0, e});
    end
    if (gb_q.size() > 0) begin
      e = gb_q.pop_front();
      chk("grant_b", {29'd0, pb0.gnt, pb1.gnt, mem_we_b, mem_addr_b}, {29'd0, e});
    end
    chk_rv(0, pa0.rvalid, pa0.rdata, "rd_a0");
    chk_rv(1, pa1.rvalid, pa1.rdata, "rd_a1");
    chk_rv(2, pb0.rvalid, pb0.rdata, "rd_b0");
    chk_rv(3, pb1.rvalid, pb1.rdata, "rd_b1");
  end

  // One cycle of stimulus on instance a, with the hand-derived grant (e0/e1).
  task automatic cyc_a(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic e0, input logic e1);
    pa0.req = r0; pa0.we = w0; pa0.addr = a0; pa0.wdata = d0;
    pa1.req = r1; pa1.we = w1; pa1.addr = a1; pa1.wdata = d1;
    ga_q.push_back({e0, e1, (e0 & w0) | (e1 & w1), e1 ? a1 : a0});
    if (e0 & !w0) rd_q[0].push_back({16'(cyc + 1), ref_mem[a0[9:2]]});
    if (e0 & w0)  ref_mem[a0[9:2]] = d0;
    if (e1 & !w1) rd_q[1].push_back({16'(cyc + 1), ref_mem[a1[9:2]]});
    if (e1 & w1)  ref_mem[a1[9:2]] = d1;
    @(posedge clk); #1;
  endtask

  task automatic rd2(input logic e0, input logic e1, input logic [31:0] a0, input logic [31:0] a1);
    cyc_a(1'b1, 1'b0, a0, 32'd0, 1'b1, 1'b0, a1, 32'd0, e0, e1);
  endtask

  task automatic idle_a(input int cycles);
    pa0.req = 1'b0;
    pa1.req = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [9:0] seq4;
    logic [3:0] hand;
    seq4 = 10'b00_1111_0000;
    hand = 4'b0111;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'hA500_0000 | 32'(i);
    pa0.req = 1'b0; pa0.we = 1'b0; pa0.addr = 32'd0; pa0.wdata = 32'd0;
    pa1.req = 1'b0; pa1.we = 1'b0; pa1.addr = 32'd0; pa1.wdata = 32'd0;
    pb0.req = 1'b0; pb0.we = 1'b0; pb0.addr = 32'd0; pb0.wdata = 32'd0;
    pb1.req = 1'b0; pb1.we = 1'b0; pb1.addr = 32'd0; pb1.wdata = 32'd0;
    reset = 1'b1;
    mem_init = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    mem_init = 1'b0;

    // Reset state
    chk("rst_rvalid0", {63'd0, pa0.rvalid}, 64'd0);
    chk("rst_rvalid1", {63'd0, pa1.rvalid}, 64'd0);
    chk("rst_rdata0", {32'd0, pa0.rdata}, 64'd0);
    chk("rst_rdata1", {32'd0, pa1.rdata}, 64'd0);
    chk("rst_gnt", {62'd0, pa0.gnt, pa1.gnt}, 64'd0);

    // Both ports reading every cycle, MAX_BURST=4: 0,0,0,0,1,1,1,1,0,0
    for (int i = 0; i < 10; i++) rd2(!seq4[i], seq4[i], 32'h20, 32'h24);
`ifdef DMEM_ARB_STATS_EN
    chk("gcnt0", {32'd0, gcnt0_a}, 64'd6);
    chk("gcnt1", {32'd0, gcnt1_a}, 64'd4);
    chk("stall_cnt", {32'd0, stall_a}, 64'd10);
`endif
    idle_a(2);

    // Port 0 write, later port 1 read of the same word
    cyc_a(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    idle_a(1);
    cyc_a(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 1'b1);
    idle_a(2);

    // Write (port 0) vs read (port 1) same address: tie to port 0, read sees new data
    cyc_a(1'b1, 1'b1, 32'h30, 32'h1234_5678, 1'b1, 1'b0, 32'h30, 32'd0, 1'b1, 1'b0);
    cyc_a(1'b0, 1'b0, 32'h30, 32'd0, 1'b1, 1'b0, 32'h30, 32'd0, 1'b0, 1'b1);
    idle_a(1);

    // Owner drops req mid-burst: immediate handover, port 1 then holds 4 grants
    cyc_a(1'b1, 1'b0, 32'h50, 32'd0, 1'b0, 1'b0, 32'h54, 32'd0, 1'b1, 1'b0);
    rd2(1'b1, 1'b0, 32'h50, 32'h54);
    cyc_a(1'b0, 1'b0, 32'h50, 32'd0, 1'b1, 1'b0, 32'h54, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) rd2(!hand[i], hand[i], 32'h50, 32'h54);
    idle_a(2);

    // Reset the cycle after a port 0 read grant
    cyc_a(1'b1, 1'b0, 32'h60, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    reset = 1'b1;
    pa0.req = 1'b0;
    pa1.req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_rvalid0", {63'd0, pa0.rvalid}, 64'd0);
    chk("rst_mid_rdata0", {32'd0, pa0.rdata}, 64'd0);
    chk("rst_mid_rdata1", {32'd0, pa1.rdata}, 64'd0);
    rd2(1'b1, 1'b0, 32'h64, 32'h68);
    idle_a(2);

    // MAX_BURST=1: strict alternation on instance b
    for (int i = 0; i < 6; i++) begin
      pb0.req = 1'b1; pb0.we = 1'b0; pb0.addr = 32'h40;
      pb1.req = 1'b1; pb1.we = 1'b0; pb1.addr = 32'h44;
      gb_q.push_back({(i % 2) == 0, (i % 2) == 1, 1'b0, ((i % 2) == 1) ? 32'h44 : 32'h40});
      if ((i % 2) == 0) rd_q[2].push_back({16'(cyc + 1), ref_mem[16]});
      else              rd_q[3].push_back({16'(cyc + 1), ref_mem[17]});
      @(posedge clk); #1;
    end
    pb0.req = 1'b0;
    pb1.req = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    chk("queues_empty",
        64'(ga_q.size() + gb_q.size() + rd_q[0].size() + rd_q[1].size() + rd_q[2].size() + rd_q[3].size()),
        64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
